// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit adder/subtractor that time-shares one 4-bit ripple slice across the operands,
// one nibble per clock, LSB nibble first, with the inter-nibble carry held in a register.
module nibble_serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = $clog2(NIB);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              v_q, v_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [3:0]        a_nib, b_nib, sum4;
  logic              c4;
  logic              last_nib;

  // Shared 4-bit slice: operates on the nibble selected by idx_q.
  always_comb begin
    a_nib       = a_q[4*idx_q +: 4];
    b_nib       = b_q[4*idx_q +: 4];
    {c4, sum4}  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    last_nib    = (idx_q == IDXW'(NIB - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_nib) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    S    = s_q;
    Cout = cout_q;
    V    = v_q;
  end

  // Subtraction is A + ~B + 1: B is inverted at latch time and the +1 enters as the initial carry.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    v_d     = v_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub;
          idx_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          v_d     = 1'b0;
        end
      end
      StRun: begin
        s_d[4*idx_q +: 4] = sum4;
        carry_d           = c4;
        idx_d             = idx_q + IDXW'(1);
        if (last_nib) begin
          cout_d = c4;
          v_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum4[3] != a_q[WIDTH-1]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      idx_q   <= idx_d;
    end
  end

endmodule
